// File: rtl/nn_fullconn_fwd_polar.sv
// nn_fullconn_fwd_polar: forward-pass fully connected stochastic layer using
// polar (magnitude + sign) bitstream arithmetic.
// For each output j, the signed popcount of (x & alpha) split by sign drives a
// saturating up/down state counter; z and zp are decoded from that state.
// A free-running frame counter marks the end of each FRAME_LEN-cycle frame.
// Optional feature macro: NN_FWD_ZCOUNT_EN adds z_count, the per-output count
// of z ones over the last completed frame.
// dbg_st exposes the packed activation states (output j at [j*SW +: SW]).
module nn_fullconn_fwd_polar #(
  parameter int N_IN      = 25,
  parameter int N_OUT     = 8,
  parameter int STATES    = 64,
  parameter int FRAME_LEN = 256
) (
  input  logic                                 CLK,
  input  logic                                 INIT,
  input  logic                                 EN,
  input  logic [N_IN-1:0]                      x,
  input  logic [N_IN-1:0]                      SIGN_x,
  input  logic [N_IN*N_OUT-1:0]                alpha,
  input  logic [N_IN*N_OUT-1:0]                SIGN_alpha,
  output logic [N_OUT-1:0]                     z,
  output logic [N_OUT-1:0]                     zp,
  output logic                                 frame_done,
  output logic [N_OUT*$clog2(STATES)-1:0]      dbg_st
`ifdef NN_FWD_ZCOUNT_EN
  ,
  output logic [N_OUT*$clog2(FRAME_LEN+1)-1:0] z_count
`endif
);

  localparam int SW   = $clog2(STATES);
  localparam int SUMW = $clog2(N_IN + 1) + 1;
  // Two guard bits above the wider operand so st + sum never wraps.
  localparam int EXTW = ((SW > SUMW) ? SW : SUMW) + 2;
  localparam int FCW  = $clog2(FRAME_LEN);

  localparam logic [SW-1:0]          MID     = SW'(STATES / 2);
  localparam logic [SW-1:0]          Q1      = SW'(STATES / 4);
  localparam logic [SW-1:0]          Q3      = SW'(3 * STATES / 4);
  localparam logic [SW-1:0]          ST_TOP  = SW'(STATES - 1);
  localparam logic signed [EXTW-1:0] ST_MAX  = EXTW'(STATES - 1);
  localparam logic [FCW-1:0]         FC_LAST = FCW'(FRAME_LEN - 1);

  logic [SW-1:0]                r_st   [N_OUT];
  logic [FCW-1:0]               r_fc;
  logic                         r_frame_done;

  logic [SUMW-1:0]              w_pos  [N_OUT];
  logic [SUMW-1:0]              w_neg  [N_OUT];
  logic signed [SUMW-1:0]       w_sum  [N_OUT];
  logic signed [EXTW-1:0]       w_ext  [N_OUT];
  logic [SW-1:0]                w_next [N_OUT];
  logic                         w_wrap;

  assign w_wrap     = EN && (r_fc == FC_LAST);
  assign frame_done = r_frame_done;

  // Signed popcount of the polar products and the clamped next state per output.
  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      w_pos[j] = '0;
      w_neg[j] = '0;
      for (int i = 0; i < N_IN; i++) begin
        if (x[i] && alpha[j*N_IN+i]) begin
          if (SIGN_x[i] ^ SIGN_alpha[j*N_IN+i]) w_neg[j] = w_neg[j] + SUMW'(1);
          else                                  w_pos[j] = w_pos[j] + SUMW'(1);
        end
      end
      w_sum[j] = $signed(w_pos[j]) - $signed(w_neg[j]);
      w_ext[j] = $signed({{(EXTW-SW){1'b0}}, r_st[j]}) + EXTW'(w_sum[j]);
      if (w_ext[j][EXTW-1])        w_next[j] = '0;
      else if (w_ext[j] > ST_MAX)  w_next[j] = ST_TOP;
      else                         w_next[j] = w_ext[j][SW-1:0];
    end
  end

  // Activation state counters: reset to MID, advance only when enabled.
  always_ff @(posedge CLK) begin
    for (int j = 0; j < N_OUT; j++) begin
      if (INIT)    r_st[j] <= MID;
      else if (EN) r_st[j] <= w_next[j];
    end
  end

  // Frame counter with a registered one-cycle pulse after the wrap edge.
  always_ff @(posedge CLK) begin
    if (INIT) begin
      r_fc         <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (w_wrap)  r_fc <= '0;
      else if (EN) r_fc <= r_fc + FCW'(1);
    end
  end

  // Output decode from state registers only; no path from the inputs.
  always_comb begin
    z      = '0;
    zp     = '0;
    dbg_st = '0;
    for (int j = 0; j < N_OUT; j++) begin
      z[j]             = (r_st[j] >= MID);
      zp[j]            = (r_st[j] >= Q1) && (r_st[j] < Q3);
      dbg_st[j*SW +: SW] = r_st[j];
    end
  end

`ifdef NN_FWD_ZCOUNT_EN
  localparam int ZW = $clog2(FRAME_LEN + 1);

  logic [ZW-1:0] r_acc [N_OUT];
  logic [ZW-1:0] r_zc  [N_OUT];

  // Count z ones over a frame; publish the total on the wrap edge together with frame_done.
  always_ff @(posedge CLK) begin
    for (int j = 0; j < N_OUT; j++) begin
      if (INIT) begin
        r_acc[j] <= '0;
        r_zc[j]  <= '0;
      end else if (w_wrap) begin
        r_zc[j]  <= r_acc[j] + ZW'(z[j]);
        r_acc[j] <= '0;
      end else if (EN) begin
        r_acc[j] <= r_acc[j] + ZW'(z[j]);
      end
    end
  end

  // Pack the per-output frame counts.
  always_comb begin
    z_count = '0;
    for (int j = 0; j < N_OUT; j++) z_count[j*ZW +: ZW] = r_zc[j];
  end
`endif

endmodule
